// File: rtl/systolic_pkg.sv
// Shared types and helpers for the weight-skewed systolic MAC row.
package systolic_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

  // Wide enough to hold any product plus accumulator without wrapping.
  localparam int unsigned SatW = 64;

  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  // Signed add clamped to an acc_w-bit signed range; sat reports that a clamp happened.
  function automatic logic signed [SatW-1:0] sat_add(input logic signed [SatW-1:0] acc,
                                                     input logic signed [SatW-1:0] prod,
                                                     input int unsigned           acc_w,
                                                     output logic                 sat);
    logic signed [SatW-1:0] sum;
    logic signed [SatW-1:0] max_v;
    logic signed [SatW-1:0] min_v;
    sum   = acc + prod;
    max_v = $signed((64'd1 << (acc_w - 1)) - 64'd1);
    min_v = -max_v - 64'sd1;
    sat   = 1'b0;
    if (sum > max_v) begin
      sum = max_v;
      sat = 1'b1;
    end else if (sum < min_v) begin
      sum = min_v;
      sat = 1'b1;
    end
    return sum;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One MAC lane: delays its weight by SKEW cycles, accumulates with saturation and forwards the
// activation stream one cycle later to the next lane.
module systolic_pe import systolic_pkg::*; #(
  parameter int unsigned W     = 8,
  parameter int unsigned ACC_W = 16,
  parameter int unsigned SKEW  = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic                    zero_acc_i,
  input  logic                    in_valid_i,
  input  logic                    in_last_i,
  input  logic signed [W-1:0]     in_a_i,
  input  logic signed [W-1:0]     in_b_i,
  output logic                    out_valid_o,
  output logic                    out_last_o,
  output logic signed [W-1:0]     out_a_o,
  output logic signed [ACC_W-1:0] acc_o,
  output logic                    valid_o,
  output logic                    overflow_o
);

  localparam int unsigned PW = 2 * W;

  logic signed [W-1:0]     b_cur;
  logic signed [PW-1:0]    prod;
  logic signed [SatW-1:0]  sum_w;
  logic                    sat;

  logic                    vld_q, vld_d;
  logic                    last_q, last_d;
  logic signed [W-1:0]     a_q, a_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    valid_q, valid_d;
  logic                    ovf_q, ovf_d;

  // Weights enter every lane at beat time; lane SKEW sees them SKEW cycles later.
  if (SKEW == 0) begin : g_noskew
    assign b_cur = in_b_i;
  end else begin : g_skew
    logic signed [W-1:0] b_pipe_q [SKEW];
    logic signed [W-1:0] b_pipe_d [SKEW];

    always_comb begin
      b_pipe_d[0] = clear_i ? '0 : in_b_i;
      for (int k = 1; k < int'(SKEW); k++) begin
        b_pipe_d[k] = clear_i ? '0 : b_pipe_q[k-1];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int k = 0; k < int'(SKEW); k++) begin
          b_pipe_q[k] <= '0;
        end
      end else begin
        for (int k = 0; k < int'(SKEW); k++) begin
          b_pipe_q[k] <= b_pipe_d[k];
        end
      end
    end

    assign b_cur = b_pipe_q[SKEW-1];
  end

  always_comb begin
    prod  = PW'(in_a_i) * PW'(b_cur);
    sum_w = sat_add(SatW'(acc_q), SatW'(prod), ACC_W, sat);
  end

  always_comb begin
    vld_d   = in_valid_i;
    last_d  = in_valid_i & in_last_i;
    a_d     = in_a_i;
    acc_d   = acc_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (clear_i) begin
      vld_d   = 1'b0;
      last_d  = 1'b0;
      a_d     = '0;
      acc_d   = '0;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end else if (start_i) begin
      valid_d = 1'b0;
      if (zero_acc_i) begin
        acc_d = '0;
        ovf_d = 1'b0;
      end
    end else if (in_valid_i) begin
      acc_d = ACC_W'(sum_w);
      ovf_d = ovf_q | sat;
      if (in_last_i) begin
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      a_q     <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      last_q  <= last_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid_o = vld_q;
  assign out_last_o  = last_q;
  assign out_a_o     = a_q;
  assign acc_o       = acc_q;
  assign valid_o     = valid_q;
  assign overflow_o  = ovf_q;

endmodule

// File: rtl/systolic_mac_row.sv
// 1-D weight-skewed systolic MAC row: run control, beat/drain counting and N_MACS lanes.
module systolic_mac_row import systolic_pkg::*; #(
  parameter int unsigned W       = 8,
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned N_MACS  = 4,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LEN_W   = len_w(MAX_LEN)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      clear_all,
  input  logic [LEN_W-1:0]          len,
  input  logic                      accum_mode,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [W-1:0]              a_data,
  input  logic [N_MACS*W-1:0]       b_data,
  output logic                      busy,
  output logic                      done,
  output logic [N_MACS*ACC_W-1:0]   acc_out,
  output logic [N_MACS-1:0]         valid_out,
  output logic [N_MACS-1:0]         overflow
);

  localparam int unsigned DrainW    = (N_MACS > 2) ? $clog2(N_MACS - 1) : 1;
  localparam int unsigned DrainLast = (N_MACS > 1) ? N_MACS - 2 : 0;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic [DrainW-1:0]  drain_q, drain_d;
  logic               done_q, done_d;

  logic               accept;
  logic               last_beat;
  logic               start_ok;
  logic               start_fire;
  logic [LEN_W-1:0]   len_clamp;

  always_comb begin
    len_clamp  = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    accept     = a_valid && (state_q == StRun);
    last_beat  = accept && ((beat_q + LEN_W'(1)) == len_q);
    start_ok   = (state_q == StIdle) && start && !clear_all;
    start_fire = start_ok && (len != '0);
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    if (clear_all) begin
      state_d = StIdle;
      beat_d  = '0;
      drain_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_fire) begin
            state_d = StRun;
            len_d   = len_clamp;
            beat_d  = '0;
          end else if (start_ok) begin
            // Zero-length run completes immediately without touching the lanes.
            done_d = 1'b1;
          end
        end
        StRun: begin
          if (accept) begin
            beat_d = beat_q + LEN_W'(1);
          end
          if (last_beat) begin
            if (N_MACS == 1) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              state_d = StDrain;
              drain_d = '0;
            end
          end
        end
        StDrain: begin
          if (drain_q == DrainW'(DrainLast)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            drain_d = drain_q + DrainW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      len_q   <= '0;
      beat_q  <= '0;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
      done_q  <= done_d;
    end
  end

  assign a_ready = (state_q == StRun);
  assign busy    = (state_q != StIdle);
  assign done    = done_q;

  logic [N_MACS:0]       pipe_vld;
  logic [N_MACS:0]       pipe_last;
  logic signed [W-1:0]   pipe_a [N_MACS+1];

  assign pipe_vld[0]  = accept;
  assign pipe_last[0] = last_beat;
  assign pipe_a[0]    = a_data;

  for (genvar g = 0; g < int'(N_MACS); g++) begin : g_lane
    systolic_pe #(
      .W     (W),
      .ACC_W (ACC_W),
      .SKEW  (g)
    ) u_pe (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .clear_i     (clear_all),
      .start_i     (start_fire),
      .zero_acc_i  (!accum_mode),
      .in_valid_i  (pipe_vld[g]),
      .in_last_i   (pipe_last[g]),
      .in_a_i      (pipe_a[g]),
      .in_b_i      (b_data[g*W +: W]),
      .out_valid_o (pipe_vld[g+1]),
      .out_last_o  (pipe_last[g+1]),
      .out_a_o     (pipe_a[g+1]),
      .acc_o       (acc_out[g*ACC_W +: ACC_W]),
      .valid_o     (valid_out[g]),
      .overflow_o  (overflow[g])
    );
  end

  // The last lane's forwarded stream has no consumer.
  logic unused_tail;
  assign unused_tail = ^{pipe_vld[N_MACS], pipe_last[N_MACS], pipe_a[N_MACS]};

endmodule

// File: tb/tb_systolic_mac_row.sv
// Self-checking bench for systolic_mac_row: table vectors, random runs and control corner cases.
module tb_systolic_mac_row;

  localparam int W       = 8;
  localparam int ACC_W   = 16;
  localparam int N       = 4;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;
  localparam int AccMax  = (1 << (ACC_W - 1)) - 1;
  localparam int AccMin  = -(1 << (ACC_W - 1));

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               clear_all = 1'b0;
  logic [LEN_W-1:0]   len = '0;
  logic               accum_mode = 1'b0;
  logic               a_valid = 1'b0;
  logic               a_ready;
  logic [W-1:0]       a_data = '0;
  logic [N*W-1:0]     b_data = '0;
  logic               busy;
  logic               done;
  logic [N*ACC_W-1:0] acc_out;
  logic [N-1:0]       valid_out;
  logic [N-1:0]       overflow;

  always #5 clk = ~clk;

  systolic_mac_row #(
    .W       (W),
    .ACC_W   (ACC_W),
    .N_MACS  (N),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .clear_all  (clear_all),
    .len        (len),
    .accum_mode (accum_mode),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_data     (a_data),
    .b_data     (b_data),
    .busy       (busy),
    .done       (done),
    .acc_out    (acc_out),
    .valid_out  (valid_out),
    .overflow   (overflow)
  );

  typedef struct {
    int       len;
    bit       mode;
    int       a0;
    int       astep;
    int       b0;
    bit       bconst;
    int       exp_acc [N];
    bit [3:0] exp_ovf;
  } vec_t;

  vec_t       vecs [8];
  int         checks = 0;
  int         errors = 0;
  int         a_seq [MAX_LEN];
  int         b_seq [MAX_LEN][N];
  int         m_acc [N];
  bit         m_ovf [N];
  logic [N-1:0] vo_hist [12];
  logic       done_hist [12];
  logic       busy_hist [12];
  int         done_cnt;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lane_acc(input int i);
    return int'($signed(acc_out[i*ACC_W +: ACC_W]));
  endfunction

  // Reference: plain saturating dot product over the beats of one run.
  task automatic model_run(input int n, input bit mode);
    int s;
    if (!mode) begin
      for (int i = 0; i < N; i++) begin
        m_acc[i] = 0;
        m_ovf[i] = 0;
      end
    end
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < N; i++) begin
        s = m_acc[i] + a_seq[k] * b_seq[k][i];
        if (s > AccMax) begin
          s = AccMax;
          m_ovf[i] = 1;
        end else if (s < AccMin) begin
          s = AccMin;
          m_ovf[i] = 1;
        end
        m_acc[i] = s;
      end
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < N; i++) begin
      m_acc[i] = 0;
      m_ovf[i] = 0;
    end
  endtask

  task automatic fill_random(input int n);
    for (int k = 0; k < n; k++) begin
      a_seq[k] = int'($urandom_range(255)) - 128;
      for (int i = 0; i < N; i++) b_seq[k][i] = int'($urandom_range(255)) - 128;
    end
  endtask

  task automatic run_job(input int len_in, input bit mode, input int gap_pct, input bit poke);
    int n;
    n = (len_in > MAX_LEN) ? MAX_LEN : len_in;
    @(posedge clk); #1;
    start      = 1'b1;
    len        = LEN_W'(len_in);
    accum_mode = mode;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        a_valid = 1'b0;
        a_data  = W'($urandom);
        b_data  = $urandom;
        @(posedge clk); #1;
      end
      a_valid = 1'b1;
      a_data  = W'(a_seq[k]);
      for (int i = 0; i < N; i++) b_data[i*W +: W] = W'(b_seq[k][i]);
      if (k == 0) check("a_ready in run", a_ready, 1);
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
    a_data  = W'($urandom);
    if (poke) begin
      start      = 1'b1;
      len        = LEN_W'(3);
      accum_mode = 1'b0;
    end
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      vo_hist[c]   = valid_out;
      done_hist[c] = done;
      busy_hist[c] = busy;
      if (done) done_cnt++;
      if (c == 1) start = 1'b0;
    end
    model_run(n, mode);
  endtask

  task automatic check_hist(input string tag);
    check({tag, " valid_out T+0"}, int'(vo_hist[0]), 1);
    check({tag, " valid_out T+1"}, int'(vo_hist[1]), 3);
    check({tag, " valid_out T+2"}, int'(vo_hist[2]), 7);
    check({tag, " valid_out T+3"}, int'(vo_hist[3]), 15);
    check({tag, " done with lane3"}, int'(done_hist[3]), 1);
    check({tag, " busy in drain"}, int'(busy_hist[2]), 1);
    check({tag, " busy falls"}, int'(busy_hist[3]), 0);
    check({tag, " done count"}, done_cnt, 1);
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s acc%0d", tag, i), lane_acc(i), m_acc[i]);
      check($sformatf("%s ovf%0d", tag, i), int'(overflow[i]), int'(m_ovf[i]));
    end
    check({tag, " valid_out"}, int'(valid_out), 15);
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < N; i++) check($sformatf("%s acc%0d", tag, i), lane_acc(i), 0);
    check({tag, " valid_out"}, int'(valid_out), 0);
    check({tag, " overflow"}, int'(overflow), 0);
    check({tag, " a_ready"}, int'(a_ready), 0);
    check({tag, " busy"}, int'(busy), 0);
  endtask

  initial begin
    vecs[0] = '{4, 1'b0, 1, 1, 1, 1'b0, '{10, 20, 30, 40}, 4'h0};
    vecs[1] = '{4, 1'b1, 1, 1, 1, 1'b0, '{20, 40, 60, 80}, 4'h0};
    vecs[2] = '{3, 1'b0, 127, 0, 127, 1'b1, '{32767, 32767, 32767, 32767}, 4'hF};
    vecs[3] = '{3, 1'b0, -128, 0, 127, 1'b1, '{-32768, -32768, -32768, -32768}, 4'hF};
    vecs[4] = '{1, 1'b1, 1, 0, 1, 1'b1, '{-32767, -32767, -32767, -32767}, 4'hF};
    vecs[5] = '{1, 1'b0, -5, 0, 3, 1'b0, '{-15, -30, -45, -60}, 4'h0};
    vecs[6] = '{2, 1'b1, 2, 0, 1, 1'b0, '{-11, -22, -33, -44}, 4'h0};
    vecs[7] = '{31, 1'b0, 1, 0, 1, 1'b0, '{16, 32, 48, 64}, 4'h0};
    model_zero();

    #3;
    check_zero("reset");
    check("reset done", int'(done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        a_seq[k] = vecs[v].a0 + k * vecs[v].astep;
        for (int i = 0; i < N; i++)
          b_seq[k][i] = vecs[v].bconst ? vecs[v].b0 : vecs[v].b0 * (i + 1);
      end
      run_job(vecs[v].len, vecs[v].mode, (v == 0) ? 0 : 30, 1'b0);
      check_hist($sformatf("vec%0d", v));
      for (int i = 0; i < N; i++) begin
        check($sformatf("vec%0d acc%0d", v, i), lane_acc(i), vecs[v].exp_acc[i]);
        check($sformatf("vec%0d ovf%0d", v, i), int'(overflow[i]), int'(vecs[v].exp_ovf[i]));
      end
      check($sformatf("vec%0d valid_out", v), int'(valid_out), 15);
    end

    for (int r = 0; r < 25; r++) begin
      int rl;
      bit rm;
      rl = int'($urandom_range(1, MAX_LEN));
      rm = 1'($urandom_range(1));
      fill_random(rl);
      run_job(rl, rm, 30, 1'b0);
      check_hist($sformatf("rand%0d", r));
      check_model($sformatf("rand%0d", r));
    end

    // clear_all on the second beat aborts the run.
    fill_random(4);
    @(posedge clk); #1;
    start = 1'b1; len = LEN_W'(4); accum_mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a_valid = 1'b1; a_data = W'(a_seq[0]); b_data = $urandom;
    @(posedge clk); #1;
    a_data = W'(a_seq[1]); clear_all = 1'b1;
    @(posedge clk); #1;
    clear_all = 1'b0; a_valid = 1'b0;
    model_zero();
    @(negedge clk);
    check_zero("clear");
    done_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("clear no done", done_cnt, 0);

    // clear_all beats a simultaneous start in IDLE.
    @(posedge clk); #1;
    start = 1'b1; clear_all = 1'b1; len = LEN_W'(4);
    @(posedge clk); #1;
    start = 1'b0; clear_all = 1'b0;
    @(negedge clk);
    check("clear beats start busy", int'(busy), 0);
    check("clear beats start done", int'(done), 0);

    // Skew registers must hold nothing stale after the abort.
    fill_random(5);
    run_job(5, 1'b1, 30, 1'b0);
    check_hist("after clear");
    check_model("after clear");

    // Zero-length start: done next cycle, lanes untouched.
    @(posedge clk); #1;
    start = 1'b1; len = '0; accum_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("len0 done", int'(done), 1);
    check("len0 busy", int'(busy), 0);
    for (int i = 0; i < N; i++) check($sformatf("len0 acc%0d", i), lane_acc(i), m_acc[i]);
    check("len0 overflow", int'(overflow), int'({m_ovf[3], m_ovf[2], m_ovf[1], m_ovf[0]}));
    @(negedge clk);
    check("len0 done pulse", int'(done), 0);

    // start during DRAIN is ignored.
    fill_random(3);
    run_job(3, 1'b0, 0, 1'b1);
    check_hist("drain start");
    check_model("drain start");
    check("drain start idle", int'(busy), 0);

    // Asynchronous reset in the middle of a run.
    fill_random(4);
    @(posedge clk); #1;
    start = 1'b1; len = LEN_W'(4); accum_mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a_valid = 1'b1; a_data = W'(a_seq[0]); b_data = $urandom;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    a_valid = 1'b0;
    model_zero();
    @(negedge clk);
    check_zero("mid reset");
    check("mid reset done", int'(done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post reset a_ready", int'(a_ready), 0);
    check("post reset busy", int'(busy), 0);
    fill_random(4);
    run_job(4, 1'b1, 20, 1'b0);
    check_hist("post reset");
    check_model("post reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
